// File: rtl/inv_bar_sprite_writer_if.sv
// inv_bar_sprite_writer_if
//  Groups the pixel-stream handshake and the sprite RAM write port of the
//  inventory-bar sprite writer.
//  Signals:
//   pix_valid / pix_rgb  : pixel source -> writer
//   pix_ready            : writer -> pixel source
//   wr_en/wr_addr/wr_data: writer -> sprite RAM write port
//  Handshake: a pixel moves on a rising clock edge where pix_valid and
//  pix_ready are both high. pix_valid may rise or fall freely and does not wait
//  for pix_ready. pix_rgb only needs to be stable in cycles where pix_valid is
//  high. The write port has no back-pressure: every cycle with wr_en high is one
//  RAM write.
//  Modports: master = pixel source / RAM side (testbench), slave = writer.
interface inv_bar_sprite_writer_if #(
  parameter int ADDR_W = 11
);
  logic              pix_valid;
  logic [23:0]       pix_rgb;
  logic              pix_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_data;

  modport master (
    output pix_valid, pix_rgb,
    input  pix_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  pix_valid, pix_rgb,
    output pix_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/inv_bar_sprite_writer.sv
// inv_bar_sprite_writer
//  Turns a streamed 24-bit RGB inventory-bar image (DEPTH pixels) into 4-bit
//  palette indices and writes them to the sprite RAM. The index is the exact
//  palette hit, otherwise the nearest entry by L1 (Manhattan) RGB distance.
//  Ties go to the lowest index.
//  Ports:
//   Clk, Reset_n : clock (rising edge) and asynchronous active-low reset
//   start        : begins a new image; only looked at in IDLE
//   bus (slave)  : pixel handshake in, sprite RAM write port out
//   busy         : high in FILL and DRAIN
//   done         : one-cycle pulse in the cycle after the last write
//   miss_count   : pixels in this image that had no exact palette hit
//   dbg_state    : current FSM state (IDLE=0, FILL=1, DRAIN=2, DONE=3)
module inv_bar_sprite_writer #(
  parameter int          DEPTH  = 1200,
  parameter int          ADDR_W = 11,
  parameter logic [23:0] PAL0   = 24'hc28d57,
  parameter logic [23:0] PAL1   = 24'he7ceb7,
  parameter logic [23:0] PAL2   = 24'h75552c,
  parameter logic [23:0] PAL3   = 24'h6f6b66,
  parameter logic [23:0] PAL4   = 24'h4751a3
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic                   start,
  inv_bar_sprite_writer_if.slave bus,
  output logic                   busy,
  output logic                   done,
  output logic [ADDR_W-1:0]      miss_count,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [23:0] PAL [5] = '{PAL0, PAL1, PAL2, PAL3, PAL4};
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [3:0]        wr_data_q;
  logic              ready;
  logic              xfer;
  logic [2:0]        best_idx;
  logic [9:0]        best_d;
  logic [9:0]        cand_d;

  // L1 distance between two RGB888 colours; max 3*255 = 765 fits in 10 bits.
  function automatic logic [9:0] rgb_dist(input logic [23:0] a, input logic [23:0] b);
    logic [7:0] dr, dg, db;
    dr = (a[23:16] > b[23:16]) ? a[23:16] - b[23:16] : b[23:16] - a[23:16];
    dg = (a[15:8]  > b[15:8])  ? a[15:8]  - b[15:8]  : b[15:8]  - a[15:8];
    db = (a[7:0]   > b[7:0])   ? a[7:0]   - b[7:0]   : b[7:0]   - a[7:0];
    return {2'b00, dr} + {2'b00, dg} + {2'b00, db};
  endfunction

  // Nearest-palette search. Strict '<' keeps the lowest index on a tie.
  always_comb begin
    best_idx = 3'd0;
    best_d   = rgb_dist(bus.pix_rgb, PAL[0]);
    cand_d   = 10'd0;
    for (int k = 1; k < 5; k++) begin
      cand_d = rgb_dist(bus.pix_rgb, PAL[k]);
      if (cand_d < best_d) begin
        best_d   = cand_d;
        best_idx = 3'(k);
      end
    end
  end

  assign ready = (state_q == FILL);
  assign xfer  = bus.pix_valid & ready;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (xfer && pix_cnt == LAST_PIX) state_d = DRAIN;
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // One-stage write pipeline: a pixel accepted in cycle N is written in N+1.
  // DRAIN is the cycle in which the final pixel's write is on the port.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pix_cnt    <= '0;
      miss_count <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 4'd0;
    end else begin
      if (state_q == IDLE && start) begin
        pix_cnt    <= '0;
        miss_count <= '0;
      end
      if (xfer) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= pix_cnt;
        wr_data_q <= {1'b0, best_idx};
        pix_cnt   <= pix_cnt + 1'b1;
        if (best_d != 10'd0 && miss_count != {ADDR_W{1'b1}})
          miss_count <= miss_count + 1'b1;
      end else begin
        wr_en_q <= 1'b0;
      end
    end
  end

  assign bus.pix_ready = ready;
  assign bus.wr_en     = wr_en_q;
  assign bus.wr_addr   = wr_addr_q;
  assign bus.wr_data   = wr_data_q;
  assign busy          = (state_q == FILL) || (state_q == DRAIN);
  assign done          = (state_q == DONE);
  assign dbg_state     = state_q;

endmodule
